// File: rtl/queue_access_arbiter_pkg.sv
// Shared encodings for the queue access arbiter: FSM states, requester ids
// and the queue data width.
package queue_access_arbiter_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_PUSH0 = 2'd0;
  localparam req_id_t REQ_PUSH1 = 2'd1;
  localparam req_id_t REQ_POP   = 2'd2;

  localparam int QUEUE_DW = 8;

  // Round-robin successor; the unused code 3 folds back onto push0.
  function automatic req_id_t next_req(input req_id_t id);
    case (id)
      REQ_PUSH0: return REQ_PUSH1;
      REQ_PUSH1: return REQ_POP;
      default:   return REQ_PUSH0;
    endcase
  endfunction

endpackage

// File: rtl/queue_access_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: searches starting at the requester
// after rr_ptr and returns the first eligible id.
module rr_pick3
  import queue_access_arbiter_pkg::*;
(
  input  logic [2:0] eligible,
  input  req_id_t    rr_ptr,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  req_id_t first_id;
  req_id_t second_id;
  req_id_t third_id;

  function automatic logic elig_of(input logic [2:0] v, input req_id_t id);
    case (id)
      REQ_PUSH0: return v[0];
      REQ_PUSH1: return v[1];
      REQ_POP:   return v[2];
      default:   return 1'b0;
    endcase
  endfunction

  always_comb begin
    first_id    = next_req(rr_ptr);
    second_id   = next_req(first_id);
    third_id    = next_req(second_id);
    grant_valid = |eligible;
    grant_id    = REQ_PUSH0;
    if (elig_of(eligible, first_id)) begin
      grant_id = first_id;
    end else if (elig_of(eligible, second_id)) begin
      grant_id = second_id;
    end else if (elig_of(eligible, third_id)) begin
      grant_id = third_id;
    end
  end

endmodule

// File: rtl/queue_access_arbiter.sv
// Shares one single-port queue between two producers and one consumer:
// ARB picks a requester round-robin, EXEC drives exactly one queue operation.
module queue_access_arbiter
  import queue_access_arbiter_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int CW    = 8
) (
  input  logic                Clk_i,
  input  logic                Rst_i,
  input  logic                push0_req_i,
  input  logic [QUEUE_DW-1:0] push0_data_i,
  output logic                push0_ack_o,
  input  logic                push1_req_i,
  input  logic [QUEUE_DW-1:0] push1_data_i,
  output logic                push1_ack_o,
  input  logic                pop_req_i,
  output logic                pop_ack_o,
  output logic                pop_valid_o,
  output logic [QUEUE_DW-1:0] pop_data_o,
  output logic                q_en_o,
  output logic                q_rw_o,
  output logic [QUEUE_DW-1:0] q_wdata_o,
  input  logic [QUEUE_DW-1:0] q_rdata_i,
  input  logic                q_empty_i,
  input  logic                q_full_i,
  output logic [CW-1:0]       count_o
);

  logic [2:0] eligible;
  logic       grant_valid;
  req_id_t    grant_id;

  state_t     state_p0;
  req_id_t    rr_ptr_p0;
  req_id_t    exec_id_p0;

  function automatic logic [CW-1:0] count_inc(input logic [CW-1:0] c);
    return (c >= CW'(DEPTH)) ? c : c + CW'(1);
  endfunction

  function automatic logic [CW-1:0] count_dec(input logic [CW-1:0] c);
    return (c == '0) ? c : c - CW'(1);
  endfunction

  function automatic logic [QUEUE_DW-1:0] push_data_mux(
    input req_id_t             id,
    input logic [QUEUE_DW-1:0] d0,
    input logic [QUEUE_DW-1:0] d1
  );
    case (id)
      REQ_PUSH0: return d0;
      REQ_PUSH1: return d1;
      default:   return '0;
    endcase
  endfunction

  always_comb begin
    eligible = {pop_req_i & ~q_empty_i,
                push1_req_i & ~q_full_i,
                push0_req_i & ~q_full_i};
  end

  rr_pick3 u_pick (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr_p0),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // ARB -> EXEC: grant registered; EXEC -> ARB: queue op retires, count moves
  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      state_p0    <= ST_ARB;
      rr_ptr_p0   <= REQ_POP;
      exec_id_p0  <= REQ_PUSH0;
      q_en_o      <= 1'b0;
      q_rw_o      <= 1'b0;
      q_wdata_o   <= '0;
      push0_ack_o <= 1'b0;
      push1_ack_o <= 1'b0;
      pop_ack_o   <= 1'b0;
      pop_valid_o <= 1'b0;
      pop_data_o  <= '0;
      count_o     <= '0;
    end else begin
      pop_valid_o <= 1'b0;
      if (state_p0 == ST_ARB) begin
        if (grant_valid) begin
          state_p0    <= ST_EXEC;
          rr_ptr_p0   <= grant_id;
          exec_id_p0  <= grant_id;
          q_en_o      <= 1'b1;
          q_rw_o      <= (grant_id != REQ_POP);
          q_wdata_o   <= push_data_mux(grant_id, push0_data_i, push1_data_i);
          push0_ack_o <= (grant_id == REQ_PUSH0);
          push1_ack_o <= (grant_id == REQ_PUSH1);
          pop_ack_o   <= (grant_id == REQ_POP);
        end else begin
          q_en_o      <= 1'b0;
          q_rw_o      <= 1'b0;
          q_wdata_o   <= '0;
          push0_ack_o <= 1'b0;
          push1_ack_o <= 1'b0;
          pop_ack_o   <= 1'b0;
        end
      end else begin
        state_p0    <= ST_ARB;
        q_en_o      <= 1'b0;
        q_rw_o      <= 1'b0;
        q_wdata_o   <= '0;
        push0_ack_o <= 1'b0;
        push1_ack_o <= 1'b0;
        pop_ack_o   <= 1'b0;
        if (exec_id_p0 == REQ_POP) begin
          pop_data_o  <= q_rdata_i;
          pop_valid_o <= 1'b1;
          count_o     <= count_dec(count_o);
        end else begin
          count_o     <= count_inc(count_o);
        end
      end
    end
  end

endmodule

// File: tb/tb_queue_access_arbiter.sv
// Directed bench for queue_access_arbiter with a behavioural single-port
// queue attached to the q_* interface.
module tb_queue_access_arbiter;

  localparam int DEPTH = 128;
  localparam int CW    = 8;

  logic       Clk_i;
  logic       Rst_i;
  logic       push0_req_i;
  logic [7:0] push0_data_i;
  logic       push0_ack_o;
  logic       push1_req_i;
  logic [7:0] push1_data_i;
  logic       push1_ack_o;
  logic       pop_req_i;
  logic       pop_ack_o;
  logic       pop_valid_o;
  logic [7:0] pop_data_o;
  logic       q_en_o;
  logic       q_rw_o;
  logic [7:0] q_wdata_o;
  logic [7:0] q_rdata_i;
  logic       q_empty_i;
  logic       q_full_i;
  logic [CW-1:0] count_o;

  int passed = 0;
  int total  = 0;

  queue_access_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .Clk_i        (Clk_i),
    .Rst_i        (Rst_i),
    .push0_req_i  (push0_req_i),
    .push0_data_i (push0_data_i),
    .push0_ack_o  (push0_ack_o),
    .push1_req_i  (push1_req_i),
    .push1_data_i (push1_data_i),
    .push1_ack_o  (push1_ack_o),
    .pop_req_i    (pop_req_i),
    .pop_ack_o    (pop_ack_o),
    .pop_valid_o  (pop_valid_o),
    .pop_data_o   (pop_data_o),
    .q_en_o       (q_en_o),
    .q_rw_o       (q_rw_o),
    .q_wdata_o    (q_wdata_o),
    .q_rdata_i    (q_rdata_i),
    .q_empty_i    (q_empty_i),
    .q_full_i     (q_full_i),
    .count_o      (count_o)
  );

  initial begin
    Clk_i = 1'b0;
    forever #5 Clk_i = ~Clk_i;
  end

  // Behavioural queue: updates on the edge that ends an EXEC cycle.
  logic [7:0] qmem [0:DEPTH-1];
  logic [6:0] qwr;
  logic [6:0] qrd;
  int         qcnt;

  always @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      qwr  <= '0;
      qrd  <= '0;
      qcnt <= 0;
    end else if (q_en_o) begin
      if (q_rw_o) begin
        qmem[qwr] <= q_wdata_o;
        qwr       <= qwr + 7'd1;
        qcnt      <= qcnt + 1;
      end else begin
        qrd  <= qrd + 7'd1;
        qcnt <= qcnt - 1;
      end
    end
  end

  assign q_rdata_i = qmem[qrd];
  assign q_empty_i = (qcnt == 0);
  assign q_full_i  = (qcnt == DEPTH);

  // Shadow count must track the real queue occupancy and stay in range.
  always @(negedge Clk_i) begin
    if (Rst_i) begin
      total = total + 1;
      if (count_o !== CW'(qcnt) || int'(count_o) > DEPTH)
        $display("FAIL shadow_count: count_o=%0d queue_occupancy=%0d", count_o, qcnt);
      else
        passed = passed + 1;
    end
  end

  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic do_reset();
    Rst_i = 1'b0;
    tick();
    tick();
    Rst_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [30:0] outs;
    Rst_i = 1'b0;
    push0_req_i = 0; push1_req_i = 0; pop_req_i = 0;
    push0_data_i = 0; push1_data_i = 0;
    repeat (3) tick();
    outs = {push0_ack_o, push1_ack_o, pop_ack_o, pop_valid_o, q_en_o, q_rw_o,
            q_wdata_o, pop_data_o, count_o};
    total++;
    if (outs !== 31'd0) $display("FAIL reset_outputs: got %h expected 0", outs);
    else passed++;
    Rst_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({q_en_o, push0_ack_o, push1_ack_o, pop_ack_o} !== 4'b0)
        $display("FAIL idle_after_reset cyc%0d: q_en/acks=%b expected 0000", i,
                 {q_en_o, push0_ack_o, push1_ack_o, pop_ack_o});
      else passed++;
    end
    total++;
    if (count_o !== 8'd0) $display("FAIL idle_count: got %0d expected 0", count_o);
    else passed++;
  endtask

  task automatic test_push_pop();
    do_reset();
    push0_data_i = 8'hA5;
    push0_req_i  = 1'b1;
    tick();
    total++;
    if ({push0_ack_o, push1_ack_o, pop_ack_o, q_en_o, q_rw_o, q_wdata_o} !== {5'b10011, 8'hA5})
      $display("FAIL push0_exec: ack0/ack1/ackp/en/rw/wdata=%b/%b/%b/%b/%b/%h expected 1/0/0/1/1/a5",
               push0_ack_o, push1_ack_o, pop_ack_o, q_en_o, q_rw_o, q_wdata_o);
    else passed++;
    push0_req_i = 1'b0;
    tick();
    total++;
    if ({q_en_o, push0_ack_o, count_o} !== {2'b00, 8'd1})
      $display("FAIL push0_retire: en=%b ack=%b count=%0d expected 0 0 1", q_en_o, push0_ack_o, count_o);
    else passed++;
    pop_req_i = 1'b1;
    tick();
    total++;
    if ({pop_ack_o, q_en_o, q_rw_o, pop_valid_o} !== 4'b1100)
      $display("FAIL pop_exec: ack/en/rw/valid=%b expected 1100", {pop_ack_o, q_en_o, q_rw_o, pop_valid_o});
    else passed++;
    pop_req_i = 1'b0;
    tick();
    total++;
    if ({pop_valid_o, pop_data_o, count_o} !== {1'b1, 8'hA5, 8'd0})
      $display("FAIL pop_data: valid=%b data=%h count=%0d expected 1 a5 0", pop_valid_o, pop_data_o, count_o);
    else passed++;
    tick();
    total++;
    if (pop_valid_o !== 1'b0) $display("FAIL pop_valid_pulse: got %b expected 0", pop_valid_o);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ack [0:2];
    exp_ack[0] = 3'b100;
    exp_ack[1] = 3'b010;
    exp_ack[2] = 3'b001;
    do_reset();
    push0_data_i = 8'h10;
    push0_req_i  = 1'b1;
    repeat (5) tick();
    push0_req_i = 1'b0;
    tick();
    pop_req_i = 1'b1;
    tick();
    pop_req_i = 1'b0;
    tick();
    total++;
    if (count_o !== 8'd2) $display("FAIL rr_preload: count=%0d expected 2", count_o);
    else passed++;
    push0_data_i = 8'h21;
    push1_data_i = 8'h42;
    push0_req_i = 1'b1; push1_req_i = 1'b1; pop_req_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if ({push0_ack_o, push1_ack_o, pop_ack_o, q_en_o} !== {exp_ack[k % 3], 1'b1})
        $display("FAIL rr_grant%0d: acks/en=%b expected %b1", k,
                 {push0_ack_o, push1_ack_o, pop_ack_o, q_en_o}, exp_ack[k % 3]);
      else passed++;
      if (k == 5) begin
        push0_req_i = 1'b0; push1_req_i = 1'b0; pop_req_i = 1'b0;
      end
      tick();
      total++;
      if ({push0_ack_o, push1_ack_o, pop_ack_o, q_en_o} !== 4'b0)
        $display("FAIL rr_gap%0d: acks/en=%b expected 0000", k,
                 {push0_ack_o, push1_ack_o, pop_ack_o, q_en_o});
      else passed++;
      if (k % 3 == 2) begin
        total++;
        if ({pop_valid_o, pop_data_o} !== {1'b1, 8'h10})
          $display("FAIL rr_pop_data%0d: valid=%b data=%h expected 1 10", k, pop_valid_o, pop_data_o);
        else passed++;
      end
    end
    total++;
    if (count_o !== 8'd4) $display("FAIL rr_count: got %0d expected 4", count_o);
    else passed++;
  endtask

  task automatic test_full();
    logic seen;
    do_reset();
    push0_data_i = 8'h11;
    push0_req_i  = 1'b1;
    repeat (256) tick();
    push0_req_i = 1'b0;
    total++;
    if ({count_o, q_full_i} !== {8'd128, 1'b1})
      $display("FAIL fill_count: count=%0d full=%b expected 128 1", count_o, q_full_i);
    else passed++;
    push1_data_i = 8'h77;
    push1_req_i  = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (push1_ack_o || q_en_o) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL push_when_full: activity=%b expected 0", seen);
    else passed++;
    pop_req_i = 1'b1;
    tick();
    total++;
    if ({pop_ack_o, push1_ack_o} !== 2'b10)
      $display("FAIL full_pop_grant: pop_ack/push1_ack=%b expected 10", {pop_ack_o, push1_ack_o});
    else passed++;
    pop_req_i = 1'b0;
    tick();
    total++;
    if ({pop_valid_o, pop_data_o, count_o} !== {1'b1, 8'h11, 8'd127})
      $display("FAIL full_pop_data: valid=%b data=%h count=%0d expected 1 11 127", pop_valid_o, pop_data_o, count_o);
    else passed++;
    tick();
    total++;
    if ({push1_ack_o, q_en_o, q_rw_o, q_wdata_o} !== {3'b111, 8'h77})
      $display("FAIL push1_after_pop: ack/en/rw=%b wdata=%h expected 111 77",
               {push1_ack_o, q_en_o, q_rw_o}, q_wdata_o);
    else passed++;
    push1_req_i = 1'b0;
    tick();
    total++;
    if (count_o !== 8'd128) $display("FAIL refill_count: got %0d expected 128", count_o);
    else passed++;
  endtask

  task automatic test_empty_pop();
    logic seen;
    do_reset();
    pop_req_i = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (pop_ack_o || q_en_o) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL pop_when_empty: activity=%b expected 0", seen);
    else passed++;
    push0_data_i = 8'h3C;
    push0_req_i  = 1'b1;
    tick();
    total++;
    if ({push0_ack_o, pop_ack_o} !== 2'b10)
      $display("FAIL empty_push_first: push0_ack/pop_ack=%b expected 10", {push0_ack_o, pop_ack_o});
    else passed++;
    push0_req_i = 1'b0;
    tick();
    tick();
    total++;
    if ({pop_ack_o, q_en_o, q_rw_o} !== 3'b110)
      $display("FAIL empty_pop_grant: ack/en/rw=%b expected 110", {pop_ack_o, q_en_o, q_rw_o});
    else passed++;
    pop_req_i = 1'b0;
    tick();
    total++;
    if ({pop_valid_o, pop_data_o} !== {1'b1, 8'h3C})
      $display("FAIL empty_pop_data: valid=%b data=%h expected 1 3c", pop_valid_o, pop_data_o);
    else passed++;
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    push0_data_i = 8'h55;
    push0_req_i  = 1'b1;
    tick();
    push0_req_i = 1'b0;
    tick();
    push0_data_i = 8'h66;
    push0_req_i  = 1'b1;
    tick();
    total++;
    if ({q_en_o, push0_ack_o, count_o} !== {2'b11, 8'd1})
      $display("FAIL pre_reset_exec: en=%b ack=%b count=%0d expected 1 1 1", q_en_o, push0_ack_o, count_o);
    else passed++;
    #2;
    Rst_i = 1'b0;
    #1;
    total++;
    if ({q_en_o, push0_ack_o, q_rw_o, count_o} !== {3'b000, 8'd0})
      $display("FAIL async_reset: en=%b ack=%b rw=%b count=%0d expected 0 0 0 0",
               q_en_o, push0_ack_o, q_rw_o, count_o);
    else passed++;
    push0_req_i = 1'b0;
    #2;
    Rst_i = 1'b1;
    tick();
    total++;
    if ({q_en_o, push0_ack_o} !== 2'b00)
      $display("FAIL first_cycle_after_release: en/ack=%b expected 00", {q_en_o, push0_ack_o});
    else passed++;
    push0_data_i = 8'h99;
    push0_req_i  = 1'b1;
    tick();
    total++;
    if ({push0_ack_o, q_en_o, q_wdata_o} !== {2'b11, 8'h99})
      $display("FAIL restart_push: ack/en=%b wdata=%h expected 11 99", {push0_ack_o, q_en_o}, q_wdata_o);
    else passed++;
    push0_req_i = 1'b0;
    tick();
    total++;
    if (count_o !== 8'd1) $display("FAIL restart_count: got %0d expected 1", count_o);
    else passed++;
  endtask

  initial begin
    Rst_i = 1'b0;
    push0_req_i = 1'b0; push1_req_i = 1'b0; pop_req_i = 1'b0;
    push0_data_i = 8'h00; push1_data_i = 8'h00;
    test_reset();
    test_push_pop();
    test_round_robin();
    test_full();
    test_empty_pop();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
